acc_alu_sequencer: RTL and testbench
====================================

Name: acc_alu_sequencer

Overview:
- Control unit for the accumulator-based processor's n-bit ALU.
- Accepts one accumulator instruction at a time over a valid/ready handshake and drives the ALU's data inputs, carry-in and 3-bit ctrl code.
- Captures the ALU result into the accumulator and maintains the C, V and Z status flags.
- Sequences a multi-cycle unsigned shift-add multiply through the same ALU.
- The ALU is instantiated outside this block; this block is its only driver.

Parameters:
- N, 8: datapath width; matches the ALU instance's n. Legal range 2..32.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- op_valid  in  1  instruction request
- op_ready  out  1  high only in IDLE; the instruction is accepted when op_valid and op_ready are both high
- opcode  in  4  instruction code; see Behaviour
- operand  in  N  memory/immediate operand
- alu_in0  out  N  ALU data input 0 (always acc)
- alu_in1  out  N  ALU data input 1
- alu_cin  out  1  ALU carry-in
- alu_ctrl  out  3  ALU operation select
- alu_out  in  N  ALU result
- alu_cout  in  1  ALU carry out
- alu_v  in  1  ALU overflow
- acc_out  out  N  accumulator
- mq_out  out  N  multiply low-half register
- flag_c  out  1  carry flag
- flag_v  out  1  overflow flag
- flag_z  out  1  zero flag
- done  out  1  one-cycle completion pulse
- illegal  out  1  pulses with done for an undefined opcode

Behaviour:
- Reset: state IDLE; acc=0, mq=0, opr=0, cnt=0; flag_c=0, flag_v=0, flag_z=1; done=0, illegal=0.
- Reset takes priority in every state and aborts a multiply with no partial write-back.
- ALU ctrl codes:
  - ADD 000 (in0+in1+cin)
  - SUB 001 (in0+~in1+cin; cin driven 1)
  - OR 010
  - AND 100
  - NOT 110 (~in0)
- States:
  - IDLE: on accept, latch opcode and operand into internal registers opr and opc. Go to MUL if opc=MUL, otherwise EXEC. op_valid while not ready is ignored.
  - EXEC: one cycle. ALU is driven from acc and opr; acc and flags are written at the end of the cycle. Go to DONE.
  - MUL: N cycles, counted by cnt 0..N-1. Go to DONE when cnt=N-1.
  - DONE: done=1 (illegal=1 if opcode ≥ 10). Return to IDLE.
- Latency: accept at edge t. Single-cycle ops: acc/flags valid and done=1 in cycle t+2. MUL: done=1 in cycle t+N+2.
- In IDLE and DONE: alu_ctrl=000, alu_in1=0, alu_cin=0.
- Opcodes:
  - 0 NOP: no state change.
  - 1 LDA: acc←opr; Z updated; C and V held.
  - 2 ADD: ctrl 000, cin 0. acc←alu_out; C←alu_cout; V←alu_v; Z updated.
  - 3 ADC: as ADD but cin=flag_c.
  - 4 SUB: ctrl 001, cin 1. Flags as ADD; C=1 means no borrow.
  - 5 AND: ctrl 100.
  - 6 OR: ctrl 010.
  - 7 NOT: ctrl 110.
  - AND/OR/NOT write acc; C←0, V←0, Z updated.
  - 8 MUL (unsigned, N×N):
    - On entry from IDLE: mq←acc, acc←0, cnt←0.
    - Each MUL cycle: ctrl 000, cin 0, in1 = mq[0] ? opr : 0.
    - Then acc←{alu_cout, alu_out[N-1:1]} and mq←{alu_out[0], mq[N-1:1]}.
    - Result: {acc, mq} = 2N-bit product.
    - Flags after the final step: C=0, V=0, Z=({acc,mq}==0).
  - 9 CMP: SUB but acc is not written; flags updated.
  - 10–15: behave as NOP plus the illegal pulse.
- Z is computed inside this block from the written result, never taken from the ALU.
- All arithmetic wraps modulo 2^N.

Decomposition:
- Shared package acc_pkg:
  - opcode constants OP_NOP..OP_CMP
  - ALU ctrl constants ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_NOT
  - state encoding (IDLE, EXEC, MUL, DONE)
- One sub-module: acc_flag_gen (combinational). Inputs: opcode, alu_out, alu_cout, alu_v, current flags, mul-final indication. Outputs: next C, V and Z.

Test Plan (N=8, ALU instance attached):
- Reset mid-MUL (rst high at MUL step 3) → next cycle IDLE, acc=0x00, mq=0x00, Z=1, op_ready=1, no done.
- LDA 0x7F then ADD 0x01 → acc=0x80, V=1, C=0, Z=0; done at t+2 for each op.
- LDA 0x05, SUB 0x05 → acc=0x00, Z=1, C=1. Then CMP 0x06 → acc stays 0x00, C=0, Z=0.
- LDA 0xFF, ADD 0x01 (C=1, acc=0x00), then ADC 0x10 → acc=0x11, C=0.
- LDA 0xFF, MUL 0xFF → done at t+10; acc=0xFE, mq=0x01, Z=0. Then LDA 0x00, MUL 0x37 → acc=0x00, mq=0x00, Z=1.
- op_valid held high with opcode 0xC while busy: accepted only in IDLE; done and illegal pulse together; acc and flags unchanged.

Source files
------------

// File: rtl/acc_pkg.sv
// Opcodes, ALU control codes and sequencer state encoding shared by the
// accumulator ALU sequencer and its flag generator.
package acc_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_ADC = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b110;

    typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} acc_state_e;

    function automatic logic is_illegal(input logic [3:0] opc);
        return opc >= 4'd10;
    endfunction

endpackage

// File: rtl/acc_alu_sequencer_if.sv
// Instruction handshake, external ALU drive/return and architectural status
// of the accumulator ALU sequencer.
interface acc_alu_sequencer_if #(
    parameter int unsigned N = 8
) ();
    logic         op_valid;
    logic         op_ready;
    logic [3:0]   opcode;
    logic [N-1:0] operand;
    logic [N-1:0] alu_in0;
    logic [N-1:0] alu_in1;
    logic         alu_cin;
    logic [2:0]   alu_ctrl;
    logic [N-1:0] alu_out;
    logic         alu_cout;
    logic         alu_v;
    logic [N-1:0] acc_out;
    logic [N-1:0] mq_out;
    logic         flag_c;
    logic         flag_v;
    logic         flag_z;
    logic         done;
    logic         illegal;

    // Requester plus ALU side.
    modport master (
        output op_valid, opcode, operand, alu_out, alu_cout, alu_v,
        input  op_ready, alu_in0, alu_in1, alu_cin, alu_ctrl,
        input  acc_out, mq_out, flag_c, flag_v, flag_z, done, illegal
    );

    // The sequencer.
    modport slave (
        input  op_valid, opcode, operand, alu_out, alu_cout, alu_v,
        output op_ready, alu_in0, alu_in1, alu_cin, alu_ctrl,
        output acc_out, mq_out, flag_c, flag_v, flag_z, done, illegal
    );
endinterface

// File: rtl/acc_flag_gen.sv
// Next-value logic for the C, V and Z status flags; Z is always derived from
// the result being written, never from the ALU.
module acc_flag_gen import acc_pkg::*; #(
    parameter int unsigned N = 8
) (
    input  logic [3:0]   opcode_i,
    input  logic [N-1:0] alu_out_i,
    input  logic         alu_cout_i,
    input  logic         alu_v_i,
    input  logic [N-1:0] opr_i,
    input  logic [N-1:1] mq_hi_i,
    input  logic         flag_c_i,
    input  logic         flag_v_i,
    input  logic         flag_z_i,
    input  logic         mul_final_i,
    output logic         flag_c_o,
    output logic         flag_v_o,
    output logic         flag_z_o
);
    always_comb begin
        flag_c_o = flag_c_i;
        flag_v_o = flag_v_i;
        flag_z_o = flag_z_i;
        if (mul_final_i) begin
            flag_c_o = 1'b0;
            flag_v_o = 1'b0;
            // Product after the last shift is {cout, alu_out, mq[N-1:1]}.
            flag_z_o = ({alu_cout_i, alu_out_i, mq_hi_i} == '0);
        end else begin
            case (opcode_i)
                OP_LDA: flag_z_o = (opr_i == '0);
                OP_ADD, OP_ADC, OP_SUB, OP_CMP: begin
                    flag_c_o = alu_cout_i;
                    flag_v_o = alu_v_i;
                    flag_z_o = (alu_out_i == '0);
                end
                OP_AND, OP_OR, OP_NOT: begin
                    flag_c_o = 1'b0;
                    flag_v_o = 1'b0;
                    flag_z_o = (alu_out_i == '0);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/acc_alu_sequencer.sv
// Control unit for the accumulator processor: accepts one instruction at a time, drives the
// external ALU, and owns acc, mq and the C/V/Z flags, including a shift-add multiply.
module acc_alu_sequencer import acc_pkg::*; #(
    parameter int unsigned N = 8
) (
    input logic                clk,
    input logic                rst,
    acc_alu_sequencer_if.slave bus
);
    localparam int unsigned CntW = $clog2(N);

    acc_state_e    state_q, state_d;
    logic [N-1:0]  acc_q, acc_d, mq_q, mq_d, opr_q, opr_d;
    logic [3:0]    opc_q, opc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          mul_init_q, mul_init_d;
    logic          flag_c_q, flag_c_d, flag_v_q, flag_v_d, flag_z_q, flag_z_d;
    logic          gen_c, gen_v, gen_z, mul_final;
    logic [N-1:0]  alu_in1;
    logic          alu_cin;
    logic [2:0]    alu_ctrl;

    assign mul_final = (state_q == StMul) && !mul_init_q && (cnt_q == CntW'(N - 1));

    acc_flag_gen #(.N(N)) u_flag_gen (
        .opcode_i    (opc_q),
        .alu_out_i   (bus.alu_out),
        .alu_cout_i  (bus.alu_cout),
        .alu_v_i     (bus.alu_v),
        .opr_i       (opr_q),
        .mq_hi_i     (mq_q[N-1:1]),
        .flag_c_i    (flag_c_q),
        .flag_v_i    (flag_v_q),
        .flag_z_i    (flag_z_q),
        .mul_final_i (mul_final),
        .flag_c_o    (gen_c),
        .flag_v_o    (gen_v),
        .flag_z_o    (gen_z)
    );

    always_comb begin
        alu_ctrl = ALU_ADD;
        alu_in1  = '0;
        alu_cin  = 1'b0;
        if (state_q == StExec) begin
            case (opc_q)
                OP_ADD: alu_in1 = opr_q;
                OP_ADC: begin
                    alu_in1 = opr_q;
                    alu_cin = flag_c_q;
                end
                OP_SUB, OP_CMP: begin
                    alu_ctrl = ALU_SUB;
                    alu_in1  = opr_q;
                    alu_cin  = 1'b1;
                end
                OP_AND: begin
                    alu_ctrl = ALU_AND;
                    alu_in1  = opr_q;
                end
                OP_OR: begin
                    alu_ctrl = ALU_OR;
                    alu_in1  = opr_q;
                end
                OP_NOT: alu_ctrl = ALU_NOT;
                default: ;
            endcase
        end else if (state_q == StMul && !mul_init_q) begin
            alu_in1 = mq_q[0] ? opr_q : '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mq_d       = mq_q;
        opr_d      = opr_q;
        opc_d      = opc_q;
        cnt_d      = cnt_q;
        mul_init_d = mul_init_q;
        flag_c_d   = flag_c_q;
        flag_v_d   = flag_v_q;
        flag_z_d   = flag_z_q;
        unique case (state_q)
            StIdle: begin
                if (bus.op_valid) begin
                    opr_d = bus.operand;
                    opc_d = bus.opcode;
                    if (bus.opcode == OP_MUL) begin
                        state_d    = StMul;
                        mul_init_d = 1'b1;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                case (opc_q)
                    OP_LDA: acc_d = opr_q;
                    OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_NOT: acc_d = bus.alu_out;
                    default: ;
                endcase
                flag_c_d = gen_c;
                flag_v_d = gen_v;
                flag_z_d = gen_z;
                state_d  = StDone;
            end
            StMul: begin
                // First cycle moves the multiplier into mq and clears the high half.
                if (mul_init_q) begin
                    mq_d       = acc_q;
                    acc_d      = '0;
                    cnt_d      = '0;
                    mul_init_d = 1'b0;
                end else begin
                    acc_d = {bus.alu_cout, bus.alu_out[N-1:1]};
                    mq_d  = {bus.alu_out[0], mq_q[N-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (mul_final) begin
                        flag_c_d = gen_c;
                        flag_v_d = gen_v;
                        flag_z_d = gen_z;
                        state_d  = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            mq_q       <= '0;
            opr_q      <= '0;
            opc_q      <= OP_NOP;
            cnt_q      <= '0;
            mul_init_q <= 1'b0;
            flag_c_q   <= 1'b0;
            flag_v_q   <= 1'b0;
            flag_z_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            opr_q      <= opr_d;
            opc_q      <= opc_d;
            cnt_q      <= cnt_d;
            mul_init_q <= mul_init_d;
            flag_c_q   <= flag_c_d;
            flag_v_q   <= flag_v_d;
            flag_z_q   <= flag_z_d;
        end
    end

    assign bus.op_ready = (state_q == StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.illegal  = (state_q == StDone) && is_illegal(opc_q);
    assign bus.alu_in0  = acc_q;
    assign bus.alu_in1  = alu_in1;
    assign bus.alu_cin  = alu_cin;
    assign bus.alu_ctrl = alu_ctrl;
    assign bus.acc_out  = acc_q;
    assign bus.mq_out   = mq_q;
    assign bus.flag_c   = flag_c_q;
    assign bus.flag_v   = flag_v_q;
    assign bus.flag_z   = flag_z_q;
endmodule

// File: tb/tb_acc_alu_sequencer.sv
// Scoreboard bench for acc_alu_sequencer with a behavioural ALU attached; directed
// instructions push hand-computed results, a negedge monitor checks them on done.
module tb_acc_alu_sequencer;
    import acc_pkg::*;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    acc_alu_sequencer_if #(.N(N)) bus ();

    acc_alu_sequencer #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural ALU.
    logic [N:0] alu_sum;
    always_comb begin
        alu_sum      = '0;
        bus.alu_out  = '0;
        bus.alu_cout = 1'b0;
        bus.alu_v    = 1'b0;
        case (bus.alu_ctrl)
            ALU_ADD: begin
                alu_sum = {1'b0, bus.alu_in0} + {1'b0, bus.alu_in1} + {{N{1'b0}}, bus.alu_cin};
                bus.alu_out  = alu_sum[N-1:0];
                bus.alu_cout = alu_sum[N];
                bus.alu_v    = (bus.alu_in0[N-1] == bus.alu_in1[N-1]) &&
                               (alu_sum[N-1] != bus.alu_in0[N-1]);
            end
            ALU_SUB: begin
                alu_sum = {1'b0, bus.alu_in0} + {1'b0, ~bus.alu_in1} + {{N{1'b0}}, bus.alu_cin};
                bus.alu_out  = alu_sum[N-1:0];
                bus.alu_cout = alu_sum[N];
                bus.alu_v    = (bus.alu_in0[N-1] != bus.alu_in1[N-1]) &&
                               (alu_sum[N-1] != bus.alu_in0[N-1]);
            end
            ALU_OR:  bus.alu_out = bus.alu_in0 | bus.alu_in1;
            ALU_AND: bus.alu_out = bus.alu_in0 & bus.alu_in1;
            ALU_NOT: bus.alu_out = ~bus.alu_in0;
            default: ;
        endcase
    end

    typedef struct {
        string      tag;
        logic [7:0] acc;
        logic [7:0] mq;
        logic       c;
        logic       v;
        logic       z;
        logic       ill;
        int         lat;
        int         acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int unsigned act,
                                  input int unsigned req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    // Monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("illegal_without_done", bus.illegal & ~bus.done, 0);
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done: done=1 at cycle %0d, required none", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.tag, "_acc"},     bus.acc_out, e.acc);
                        check({e.tag, "_mq"},      bus.mq_out,  e.mq);
                        check({e.tag, "_c"},       bus.flag_c,  e.c);
                        check({e.tag, "_v"},       bus.flag_v,  e.v);
                        check({e.tag, "_z"},       bus.flag_z,  e.z);
                        check({e.tag, "_illegal"}, bus.illegal, e.ill);
                        check({e.tag, "_latency"}, cyc - e.acc_cyc + 1, e.lat);
                    end
                end
            end
        end
    end

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d ops pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] a, input logic [7:0] m,
                            input logic c, input logic v, input logic z, input logic ill,
                            input int lat);
        exp_t e;
        e.tag = tag; e.acc = a; e.mq = m; e.c = c; e.v = v; e.z = z; e.ill = ill;
        e.lat = lat;
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic issue(input string tag, input logic [3:0] opc, input logic [7:0] opnd,
                         input logic [7:0] a, input logic [7:0] m, input logic c,
                         input logic v, input logic z, input logic ill, input int lat);
        @(negedge clk);
        check({tag, "_ready"}, bus.op_ready, 1);
        bus.op_valid = 1'b1;
        bus.opcode   = opc;
        bus.operand  = opnd;
        push_exp(tag, a, m, c, v, z, ill, lat);
        @(negedge clk);
        bus.op_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        bus.opcode   = OP_NOP;
        bus.operand  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready",   bus.op_ready, 1);
        check("rst_acc",     bus.acc_out,  0);
        check("rst_mq",      bus.mq_out,   0);
        check("rst_c",       bus.flag_c,   0);
        check("rst_v",       bus.flag_v,   0);
        check("rst_z",       bus.flag_z,   1);
        check("rst_done",    bus.done,     0);
        check("rst_illegal", bus.illegal,  0);

        // Reset aborts a multiply in progress.
        issue("lda03", OP_LDA, 8'h03, 8'h03, 8'h00, 0, 0, 0, 0, 2);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.opcode   = OP_MUL;
        bus.operand  = 8'h05;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", bus.op_ready, 1);
        check("abort_acc",   bus.acc_out,  0);
        check("abort_mq",    bus.mq_out,   0);
        check("abort_z",     bus.flag_z,   1);
        check("abort_done",  bus.done,     0);
        rst = 1'b0;

        issue("lda7f",  OP_LDA, 8'h7F, 8'h7F, 8'h00, 0, 0, 0, 0, 2);
        issue("add01",  OP_ADD, 8'h01, 8'h80, 8'h00, 0, 1, 0, 0, 2);
        issue("lda05",  OP_LDA, 8'h05, 8'h05, 8'h00, 0, 1, 0, 0, 2);
        issue("sub05",  OP_SUB, 8'h05, 8'h00, 8'h00, 1, 0, 1, 0, 2);
        issue("cmp06",  OP_CMP, 8'h06, 8'h00, 8'h00, 0, 0, 0, 0, 2);
        issue("ldaff",  OP_LDA, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 0, 2);
        issue("addc",   OP_ADD, 8'h01, 8'h00, 8'h00, 1, 0, 1, 0, 2);
        issue("adc10",  OP_ADC, 8'h10, 8'h11, 8'h00, 0, 0, 0, 0, 2);
        issue("ldaff2", OP_LDA, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 0, 2);
        issue("mulff",  OP_MUL, 8'hFF, 8'hFE, 8'h01, 0, 0, 0, 0, 10);
        issue("lda00",  OP_LDA, 8'h00, 8'h00, 8'h01, 0, 0, 1, 0, 2);
        issue("mul37",  OP_MUL, 8'h37, 8'h00, 8'h00, 0, 0, 1, 0, 10);
        issue("ldaf0",  OP_LDA, 8'hF0, 8'hF0, 8'h00, 0, 0, 0, 0, 2);
        issue("and3c",  OP_AND, 8'h3C, 8'h30, 8'h00, 0, 0, 0, 0, 2);
        issue("or0f",   OP_OR,  8'h0F, 8'h3F, 8'h00, 0, 0, 0, 0, 2);
        issue("not",    OP_NOT, 8'h00, 8'hC0, 8'h00, 0, 0, 0, 0, 2);
        issue("lda80",  OP_LDA, 8'h80, 8'h80, 8'h00, 0, 0, 0, 0, 2);
        issue("sub01",  OP_SUB, 8'h01, 8'h7F, 8'h00, 1, 1, 0, 0, 2);
        issue("nop",    OP_NOP, 8'h5A, 8'h7F, 8'h00, 1, 1, 0, 0, 2);
        issue("lda0d",  OP_LDA, 8'h0D, 8'h0D, 8'h00, 1, 1, 0, 0, 2);
        issue("mul0b",  OP_MUL, 8'h0B, 8'h00, 8'h8F, 0, 0, 0, 0, 10);
        issue("lda22",  OP_LDA, 8'h22, 8'h22, 8'h8F, 0, 0, 0, 0, 2);
        issue("ill_f",  4'hF,   8'h00, 8'h22, 8'h8F, 0, 0, 0, 1, 2);

        // Illegal opcode held valid: accepted only when idle, every third cycle.
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.opcode   = 4'hC;
        bus.operand  = 8'hAA;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            check("held_ready", bus.op_ready, (k % 3 == 0));
            if (k % 3 == 0) push_exp("held_c", 8'h22, 8'h8F, 0, 0, 0, 1, 2);
        end
        @(negedge clk);
        bus.op_valid = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("final_ready", bus.op_ready, 1);
        check("final_acc",   bus.acc_out,  8'h22);
        check("final_z",     bus.flag_z,   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
